// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register-bank responder: NUM_REGS x 32-bit registers with per-register write pulses.
// Optional macro AXI_LITE_SLV_ADDR_ERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int                    IDXW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);
`ifdef AXI_LITE_SLV_ADDR_ERR_EN
  localparam bit ADDR_ERR = 1'b1;
`else
  localparam bit ADDR_ERR = 1'b0;
`endif

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  wr_state_t wr_state, wr_next;

  logic                  up;
  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [ADDR_WIDTH-1:0] w_off, r_off;
  logic                  w_hit, r_hit;
  logic [IDXW-1:0]       w_idx, r_idx;
  logic [31:0]           regs [NUM_REGS];

  // Ready outputs stay low until the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) up <= 1'b0;
    else       up <= 1'b1;
  end

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign arready = up & ~rvalid;
  assign ar_hs   = arvalid & arready;

  assign w_off = aw_addr - BASE;
  assign w_hit = w_off < SPAN;
  assign w_idx = w_off[2 +: IDXW];
  assign r_off = araddr - BASE;
  assign r_hit = r_off < SPAN;
  assign r_idx = r_off[2 +: IDXW];

  always_ff @(posedge clk) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_COMMIT;
        else if (aw_hs)    wr_next = WR_ADDR;
        else if (w_hs)     wr_next = WR_DATA;
      end
      WR_ADDR:   if (w_hs)   wr_next = WR_COMMIT;
      WR_DATA:   if (aw_hs)  wr_next = WR_COMMIT;
      WR_COMMIT:             wr_next = WR_RESP;
      WR_RESP:   if (bready) wr_next = WR_IDLE;
      default:               wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready = up;
        wready  = up;
      end
      WR_ADDR: wready  = up;
      WR_DATA: awready = up;
      WR_RESP: bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr <= awaddr;
    if (w_hs) begin
      w_data <= wdata;
      w_strb <= wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse_o <= '0;
      bresp      <= 2'b00;
    end else begin
      wr_pulse_o <= '0;
      if (wr_state == WR_COMMIT) begin
        bresp <= (ADDR_ERR && !w_hit) ? 2'b10 : 2'b00;
        if (w_hit) begin
          wr_pulse_o[w_idx] <= 1'b1;
          for (int unsigned b = 0; b < 4; b++)
            if (w_strb[b]) regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // A read sampled on the commit edge sees the pre-write register contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= r_hit ? regs[r_idx] : '0;
      rresp  <= (ADDR_ERR && !r_hit) ? 2'b10 : 2'b00;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_axi_lite_reg_slave;

  localparam int          AW   = 32;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h4000_1000;
`ifdef AXI_LITE_SLV_ADDR_ERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   awaddr = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [31:0]     wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]   wr_pulse_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mreg [NR];

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(NR * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (!m_hit(a)) return;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mreg[m_idx(a)] = (mreg[m_idx(a)] & ~mask) | (d & mask);
  endfunction

  function automatic logic [NR*32-1:0] m_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = mreg[i];
    return f;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NR; i++) mreg[i] = '0;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse,
                           output logic [NR-1:0] pulse_after, output int lat, output bit to);
    bit aw_done, w_done, hsa, hsw;
    int c;
    aw_done = 0; w_done = 0; c = 0; to = 0; lat = 0;
    resp = 'x; pulse = 'x; pulse_after = 'x;
    bready = 1'b0; awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 100) begin
      awvalid = !aw_done && c >= aw_dly;
      wvalid  = !w_done && c >= w_dly;
      hsa = awvalid && awready;
      hsw = wvalid && wready;
      tick();
      c++;
      if (hsa) aw_done = 1;
      if (hsw) w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin to = 1; return; end
    lat = 1;
    while (!bvalid && lat < 100) begin tick(); lat++; end
    if (!bvalid) begin to = 1; return; end
    resp = bresp; pulse = wr_pulse_o;
    bready = 1'b1; tick(); bready = 1'b0;
    pulse_after = wr_pulse_o;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output bit to);
    int c;
    c = 0; to = 0; lat = 0; d = 'x; resp = 'x;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    while (!arready && c < 100) begin tick(); c++; end
    if (!arready) begin arvalid = 1'b0; to = 1; return; end
    tick(); arvalid = 1'b0; lat = 1;
    while (!rvalid && lat < 100) begin tick(); lat++; end
    if (!rvalid) begin to = 1; return; end
    d = rdata; resp = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    n_cmp++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_bad++;
      $display("FAIL rst_handshake got=%b want=00000", {awready, wready, arready, bvalid, rvalid}); end
    n_cmp++; if ({bresp, rresp} !== 4'b0) begin n_bad++; $display("FAIL rst_resp got=%b want=0000", {bresp, rresp}); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++; $display("FAIL rst_pulse got=%h want=0", wr_pulse_o); end
    n_cmp++; if (regs_o !== '0) begin n_bad++; $display("FAIL rst_regs got=%h want=0", regs_o); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_bad++;
      $display("FAIL rst_ready_after got=%b want=111", {awready, wready, arready}); end
    m_clear();
  endtask

  task automatic test_simul_write();
    logic [1:0] resp; logic [NR-1:0] p, pa; int lat; bit to;
    m_write(BASE + 32'h4, 32'hA5A5_1234, 4'hF);
    bus_write(BASE + 32'h4, 32'hA5A5_1234, 4'hF, 0, 0, resp, p, pa, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL simul_timeout got=%b want=0", to); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL simul_b_latency got=%0d want=2", lat); end
    n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL simul_bresp got=%b want=00", resp); end
    n_cmp++; if (regs_o[63:32] !== 32'hA5A5_1234) begin n_bad++; $display("FAIL simul_reg1 got=%h want=a5a51234", regs_o[63:32]); end
    n_cmp++; if (p !== 8'h02) begin n_bad++; $display("FAIL simul_pulse got=%h want=02", p); end
    n_cmp++; if (pa !== 8'h00) begin n_bad++; $display("FAIL simul_pulse_width got=%h want=00", pa); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [NR-1:0] p, pa; int lat; bit to;
    m_write(BASE + 32'h8, 32'h1122_3344, 4'hF);
    bus_write(BASE + 32'h8, 32'h1122_3344, 4'hF, 0, 0, resp, p, pa, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wfirst_setup_timeout got=%b want=0", to); end
    wdata = 32'hFFFF_FFFF; wstrb = 4'b0101; wvalid = 1'b1;
    n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL wfirst_wready_idle got=%b want=1", wready); end
    tick(); wvalid = 1'b0;
    repeat (3) begin
      n_cmp++; if ({wready, bvalid} !== 2'b00) begin n_bad++;
        $display("FAIL wfirst_hold got=%b want=00", {wready, bvalid}); end
      tick();
    end
    awaddr = BASE + 32'h8; awvalid = 1'b1;
    n_cmp++; if (awready !== 1'b1) begin n_bad++; $display("FAIL wfirst_awready got=%b want=1", awready); end
    tick(); awvalid = 1'b0;
    n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL wfirst_wready_both got=%b want=0", wready); end
    tick();
    m_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'b0101);
    n_cmp++; if ({bvalid, bresp, wready} !== 4'b1000) begin n_bad++;
      $display("FAIL wfirst_b got=%b want=1000", {bvalid, bresp, wready}); end
    n_cmp++; if (regs_o[95:64] !== 32'h11FF_33FF) begin n_bad++; $display("FAIL wfirst_reg2 got=%h want=11ff33ff", regs_o[95:64]); end
    bready = 1'b1; tick(); bready = 1'b0;
    n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL wfirst_wready_after got=%b want=1", wready); end
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d3, d5;
    d3 = $urandom; d5 = $urandom;
    awaddr = BASE + 32'hC; wdata = d3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    tick();
    m_write(BASE + 32'hC, d3, 4'hF);
    awaddr = BASE + 32'h14; awvalid = 1'b1;
    repeat (10) begin
      n_cmp++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin n_bad++;
        $display("FAIL bstall_hold got=%b want=10000", {bvalid, bresp, awready, wready}); end
      tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
    n_cmp++; if ({bvalid, awready} !== 2'b01) begin n_bad++; $display("FAIL bstall_release got=%b want=01", {bvalid, awready}); end
    wdata = d5; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    tick();
    m_write(BASE + 32'h14, d5, 4'hF);
    n_cmp++; if (bvalid !== 1'b1) begin n_bad++; $display("FAIL bstall_second_b got=%b want=1", bvalid); end
    n_cmp++; if (regs_o !== m_flat()) begin n_bad++; $display("FAIL bstall_regs got=%h want=%h", regs_o, m_flat()); end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic test_read_backpressure();
    araddr = BASE + 32'h4; arvalid = 1'b1;
    n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL rstall_arready got=%b want=1", arready); end
    tick(); arvalid = 1'b0;
    repeat (4) begin
      n_cmp++; if ({rvalid, arready, rresp} !== 4'b1000) begin n_bad++;
        $display("FAIL rstall_hold got=%b want=1000", {rvalid, arready, rresp}); end
      n_cmp++; if (rdata !== 32'hA5A5_1234) begin n_bad++; $display("FAIL rstall_rdata got=%h want=a5a51234", rdata); end
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    n_cmp++; if ({rvalid, arready} !== 2'b01) begin n_bad++; $display("FAIL rstall_release got=%b want=01", {rvalid, arready}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    arvalid = 1'b1; rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(0, 3);
      araddr = a;
      n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL b2b_arready got=%b want=1", arready); end
      tick();
      n_cmp++; if ({rvalid, arready} !== 2'b10) begin n_bad++; $display("FAIL b2b_rvalid got=%b want=10", {rvalid, arready}); end
      n_cmp++; if (rdata !== mreg[m_idx(a)]) begin n_bad++; $display("FAIL b2b_rdata got=%h want=%h", rdata, mreg[m_idx(a)]); end
      tick();
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [31:0] oldv, newv;
    oldv = mreg[6]; newv = $urandom;
    awaddr = BASE + 32'h18; wdata = newv; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    araddr = BASE + 32'h18; arvalid = 1'b1;
    tick(); arvalid = 1'b0;
    m_write(BASE + 32'h18, newv, 4'hF);
    n_cmp++; if ({rvalid, bvalid} !== 2'b11) begin n_bad++; $display("FAIL conc_valids got=%b want=11", {rvalid, bvalid}); end
    n_cmp++; if (rdata !== oldv) begin n_bad++; $display("FAIL conc_old_value got=%h want=%h", rdata, oldv); end
    n_cmp++; if (regs_o[32*6 +: 32] !== newv) begin n_bad++; $display("FAIL conc_new_value got=%h want=%h", regs_o[32*6 +: 32], newv); end
    rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    logic [1:0] resp; logic [NR-1:0] p, pa; logic [31:0] d; int lat; bit to;
    addrs[0] = BASE + 32'h40; addrs[1] = BASE - 32'h4;
    for (int k = 0; k < 2; k++) begin
      bus_write(addrs[k], $urandom, 4'hF, 0, 0, resp, p, pa, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL unmap_wr_timeout got=%b want=0", to); end
      n_cmp++; if (resp !== ERR_RESP) begin n_bad++; $display("FAIL unmap_bresp got=%b want=%b", resp, ERR_RESP); end
      n_cmp++; if (p !== '0) begin n_bad++; $display("FAIL unmap_pulse got=%h want=0", p); end
      n_cmp++; if (regs_o !== m_flat()) begin n_bad++; $display("FAIL unmap_regs got=%h want=%h", regs_o, m_flat()); end
      bus_read(addrs[k], d, resp, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL unmap_rd_timeout got=%b want=0", to); end
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmap_rdata got=%h want=0", d); end
      n_cmp++; if (resp !== ERR_RESP) begin n_bad++; $display("FAIL unmap_rresp got=%b want=%b", resp, ERR_RESP); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed; logic [3:0] s; logic [1:0] resp, er;
    logic [NR-1:0] p, pa, ep; int lat; bit to, hit;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) a = BASE + 32'(NR * 4) + 4 * $urandom_range(0, 100);
      else a = BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(0, 3);
      hit = m_hit(a);
      er = hit ? 2'b00 : ERR_RESP;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        ep = '0;
        if (hit) ep[m_idx(a)] = 1'b1;
        m_write(a, d, s);
        bus_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, p, pa, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rnd_wr_timeout addr=%h got=%b want=0", a, to); end
        n_cmp++; if (resp !== er) begin n_bad++; $display("FAIL rnd_bresp addr=%h got=%b want=%b", a, resp, er); end
        n_cmp++; if (p !== ep) begin n_bad++; $display("FAIL rnd_pulse addr=%h got=%h want=%h", a, p, ep); end
        n_cmp++; if (regs_o !== m_flat()) begin n_bad++; $display("FAIL rnd_regs addr=%h got=%h want=%h", a, regs_o, m_flat()); end
      end else begin
        ed = hit ? mreg[m_idx(a)] : 32'h0;
        bus_read(a, d, resp, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rnd_rd_timeout addr=%h got=%b want=0", a, to); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rnd_rd_latency addr=%h got=%0d want=1", a, lat); end
        n_cmp++; if (d !== ed) begin n_bad++; $display("FAIL rnd_rdata addr=%h got=%h want=%h", a, d, ed); end
        n_cmp++; if (resp !== er) begin n_bad++; $display("FAIL rnd_rresp addr=%h got=%b want=%b", a, resp, er); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    d = $urandom;
    awaddr = BASE; awvalid = 1'b1; araddr = BASE + 32'h4; arvalid = 1'b1;
    tick(); awvalid = 1'b0; arvalid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    m_clear();
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_rvalid got=%b want=0", rvalid); end
    n_cmp++; if (regs_o !== '0) begin n_bad++; $display("FAIL midrst_regs got=%h want=0", regs_o); end
    tick();
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    n_cmp++; if ({awready, wready} !== 2'b11) begin n_bad++; $display("FAIL midrst_ready got=%b want=11", {awready, wready}); end
    tick(); wvalid = 1'b0;
    repeat (3) begin
      n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_commit got=%b want=0", bvalid); end
      tick();
    end
    awaddr = BASE + 32'h1C; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    tick();
    m_write(BASE + 32'h1C, d, 4'hF);
    n_cmp++; if (bvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_b got=%b want=1", bvalid); end
    n_cmp++; if (regs_o !== m_flat()) begin n_bad++; $display("FAIL midrst_regs_after got=%h want=%h", regs_o, m_flat()); end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  initial begin
    m_clear();
    test_reset();
    test_simul_write();
    test_w_before_aw();
    test_b_backpressure();
    test_read_backpressure();
    test_back_to_back();
    test_concurrent();
    test_unmapped();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
